// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cnn_pkg
// Brief    : Shared types and helpers for the CNN weight loading path.
// Revision : 1.0 - initial release
// ============================================================================
package cnn_pkg;

    typedef logic signed [1:0] weight_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } loader_state_t;

    // Number of weights in one square kernel.
    function automatic int kk_of(input int kernel_size);
        return kernel_size * kernel_size;
    endfunction

endpackage
`default_nettype wire

// File: rtl/feature_weight_loader.sv
`default_nettype none
// ============================================================================
// Module   : feature_weight_loader
// Brief    : Assembles streamed 2-bit weights into kernels and writes them,
//            one feature at a time, into the feature weight memory.
// Revision : 1.0 - initial release
// ============================================================================
module feature_weight_loader
    import cnn_pkg::*;
#(
    parameter int KERNEL_SIZE  = 3,
    parameter int NUM_FEATURES = 10
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic                                 abort,
    input  logic                                 w_valid,
    input  logic [1:0]                           w_data,
    output logic                                 w_ready,
    output logic                                 feature_WrEn,
    output logic [$clog2(NUM_FEATURES):0]        address_w,
    output logic signed [1:0]                    feature_weights_input [KERNEL_SIZE*KERNEL_SIZE],
    output logic                                 busy,
    output logic                                 done,
    output logic                                 weights_loaded
);

    localparam int c_KK = kk_of(KERNEL_SIZE);
    localparam int c_EW = $clog2(c_KK);
    localparam int c_AW = $clog2(NUM_FEATURES) + 1;

    loader_state_t   r_state;
    loader_state_t   w_state_nxt;
    logic [c_EW-1:0] r_elem_cnt;
    logic [c_AW-1:0] r_feat_cnt;
    logic            r_loaded;
    weight_t         r_kernel [c_KK];

    logic w_xfer;
    logic w_last_elem;
    logic w_last_feat;

    assign w_xfer      = w_valid && (r_state == COLLECT);
    assign w_last_elem = (r_elem_cnt == c_EW'(c_KK - 1));
    assign w_last_feat = (r_feat_cnt == c_AW'(NUM_FEATURES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_elem_cnt <= '0;
            r_feat_cnt <= '0;
            r_loaded   <= 1'b0;
            for (int i = 0; i < c_KK; i++) begin
                r_kernel[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            if (abort) begin
                r_elem_cnt <= '0;
                r_feat_cnt <= '0;
                r_loaded   <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (start) begin
                            r_elem_cnt <= '0;
                            r_feat_cnt <= '0;
                            r_loaded   <= 1'b0;
                        end
                    end
                    COLLECT: begin
                        if (w_xfer) begin
                            r_kernel[r_elem_cnt] <= weight_t'(w_data);
                            r_elem_cnt           <= w_last_elem ? '0 : r_elem_cnt + 1'b1;
                        end
                    end
                    WRITE: begin
                        // Address must hold for the whole write cycle, so the
                        // feature index only advances at its closing edge.
                        if (!w_last_feat) begin
                            r_feat_cnt <= r_feat_cnt + 1'b1;
                        end
                    end
                    DONE: begin
                        r_loaded <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Next state plus outputs decoded purely from registered state, so there
    // is no combinational path from the stream inputs to w_ready.
    always_comb begin
        w_state_nxt  = r_state;
        w_ready      = 1'b0;
        feature_WrEn = 1'b1;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_state_nxt = COLLECT;
            end
            COLLECT: begin
                w_ready = 1'b1;
                busy    = 1'b1;
                if (w_xfer && w_last_elem) w_state_nxt = WRITE;
            end
            WRITE: begin
                feature_WrEn = 1'b0;
                busy         = 1'b1;
                w_state_nxt  = w_last_feat ? DONE : COLLECT;
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        if (abort) w_state_nxt = IDLE;
    end

    assign address_w             = r_feat_cnt;
    assign weights_loaded        = r_loaded;
    assign feature_weights_input = r_kernel;

endmodule
`default_nettype wire

// File: doc/feature_weight_loader.md
Name: feature_weight_loader

Overview:
Sequences the loading of convolution feature weights into the feature weight memory before a CNN inference run. Accepts a serial stream of signed 2-bit weights over a valid/ready handshake and assembles each KERNEL_SIZE*KERNEL_SIZE kernel. Drives the memory's active-low write enable, write address and kernel vector for features 0..NUM_FEATURES-1. Signals completion to the top-level control so PEs can start MAC operation.

Parameters:
KERNEL_SIZE, 3, kernel edge length; KK = KERNEL_SIZE*KERNEL_SIZE weights per feature
NUM_FEATURES, 10, number of feature kernels to load

Ports:
clk  in  1  system clock; all loader logic on posedge
rst  in  1  reset, asynchronous, active-low
start  in  1  begin a load sequence; honoured only in IDLE
abort  in  1  synchronous abort; returns to IDLE from any state
w_valid  in  1  stream weight valid
w_data  in  2  stream weight, signed 2-bit
w_ready  out  1  loader can accept w_data this cycle
feature_WrEn  out  1  memory write enable, active-low
address_w  out  $clog2(NUM_FEATURES)+1  memory write address (feature index)
feature_weights_input  out  2 x KK (unpacked [KK], signed)  assembled kernel to memory
busy  out  1  high in COLLECT and WRITE
done  out  1  one-cycle pulse when last feature written
weights_loaded  out  1  sticky: all NUM_FEATURES kernels written since last start

Behaviour:
- Reset (rst=0, async): state=IDLE; feature_WrEn=1; address_w=0; feature_weights_input all 0; w_ready=0; busy=0; done=0; weights_loaded=0; elem_cnt=0; feat_cnt=0. No write can be issued during or from reset, including mid-sequence.
- All outputs registered or decoded from registered state; no combinational path from w_valid to w_ready.
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE: w_ready=0. start=1 -> COLLECT next cycle; clear elem_cnt, feat_cnt; weights_loaded <= 0.
- COLLECT: w_ready=1. Transfer = w_valid & w_ready. On transfer, weight stored at feature_weights_input[elem_cnt], elem_cnt++. w_valid gaps: hold state, no change. Transfer with elem_cnt==KK-1 -> WRITE; elem_cnt <= 0.
- WRITE: exactly one cycle; feature_WrEn=0; address_w=feat_cnt; w_ready=0. The memory samples on negedge clk, mid-cycle. Address and kernel vector are stable for the whole cycle. Exit: feat_cnt==NUM_FEATURES-1 -> DONE; else feat_cnt++, -> COLLECT.
- DONE: one cycle; done=1; weights_loaded <= 1; -> IDLE. weights_loaded stays 1 until the next accepted start or reset.
- feature_WrEn is high in every state except WRITE.
- address_w never exceeds NUM_FEATURES-1.
- start outside IDLE: ignored.
- abort (priority over start and all transitions): -> IDLE next cycle. If abort is high during WRITE, that cycle's write still completes (the negedge has already occurred). Counters cleared; weights_loaded=0; done not pulsed.
- Memory contents from an aborted run are partial. A new start rewrites all features.
- Throughput: KK transfers + 1 write cycle per feature. Minimum total = NUM_FEATURES*(KK+1) cycles from start to the WRITE of the last feature, plus 1 DONE cycle. Defaults: 100 + 1, plus the start-acceptance cycle.
- Counters: elem_cnt width $clog2(KK); feat_cnt width matches address_w.

Decomposition:
- Shared package cnn_pkg:
  - typedef weight_t = logic signed [1:0]
  - loader_state_t enum {IDLE, COLLECT, WRITE, DONE}
  - localparam KK derivation helper
  - (KERNEL_SIZE and NUM_FEATURES remain module parameters)
- No sub-module required. The FSM, counters and kernel register fit in one module. Optionally factor kernel_assembler (indexed store of KK weights) if it is reused by an image-row loader.

Test Plan:
- Reset values: assert rst=0 mid-COLLECT (feature 4, elem 5) -> all outputs at reset values immediately, feature_WrEn=1, no memory write; after release, state IDLE.
- Full load: start, stream weight value ((f+e) mod 4) mapped to {-2..1} for f=0..9, e=0..8 with w_valid held high -> exactly 10 WRITE cycles at addresses 0..9. Memory readback matches the pattern. done pulses once at cycle 102 after start; weights_loaded=1.
- Backpressure/gaps: w_valid toggling 1-0-1 randomly -> identical memory contents. w_ready=0 in WRITE; no weight is lost or duplicated at the elem 8 -> WRITE boundary.
- start while busy: pulse start during feature 3 -> ignored; sequence and counters unaffected.
- Abort: abort at feature 6, elem 2 -> IDLE next cycle; no further writes; done=0; weights_loaded=0. A subsequent start performs a full 10-feature load from address 0.
- Abort during WRITE of feature 2 -> address 2 written once; state IDLE next; no write to address 3.
